proc_run_ctrl: RTL and testbench

Run controller that sequences the single-cycle processor (`singlecycle`) through one program execution: it holds the core in reset, drives its start PC, releases it, monitors `currentpc` against a final PC, and terminates the run on completion or on a watchdog expiry. It sits between the system or bench and the core's `resetl`/`startpc` pins. It replaces the ad-hoc reset, compare and watchdog sequencing otherwise done in testbenches.

---
 rtl/proc_run_ctrl_if.sv | 32 +++
 rtl/proc_run_ctrl.sv | 120 ++++++++++++
 tb/tb_proc_run_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/proc_run_ctrl_if.sv
// Run-controller bundle: host request/status plus the core-facing reset, start PC and PC feedback.
// The controller takes the slave modport; the system or bench takes master.
interface proc_run_ctrl_if #(
  parameter int WD_WIDTH = 16
);
  // start is a one-cycle pulse with no ready: it is taken on the edge where it is
  // sampled high only while the controller is idle/done/timeout, otherwise dropped.
  logic                start;
  logic [63:0]         start_pc;
  logic [63:0]         final_pc;
  logic [WD_WIDTH-1:0] wd_limit;
  logic [63:0]         currentpc;

  logic                proc_resetl;
  logic [63:0]         proc_startpc;
  logic                busy;
  logic                done;
  logic                timeout;
  logic [WD_WIDTH-1:0] cycle_count;
  logic [63:0]         last_pc;
  logic [2:0]          dbg_state;

  modport master (
    output start, start_pc, final_pc, wd_limit, currentpc,
    input  proc_resetl, proc_startpc, busy, done, timeout, cycle_count, last_pc, dbg_state
  );

  modport slave (
    input  start, start_pc, final_pc, wd_limit, currentpc,
    output proc_resetl, proc_startpc, busy, done, timeout, cycle_count, last_pc, dbg_state
  );
endinterface

// File: rtl/proc_run_ctrl.sv
// Sequences the single-cycle core through one program run: reset hold, release, final-PC watch.
// Optional watchdog timeout is compiled in with `define PROC_RUN_WATCHDOG_EN.
module proc_run_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int WD_WIDTH     = 16
) (
  input logic            CLK,
  input logic            resetl,
  proc_run_ctrl_if.slave bus
);

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  state_e              state_q;
  logic [RCW-1:0]      rst_cnt_q;
  logic [63:0]         start_pc_q;
  logic [63:0]         final_pc_q;
`ifdef PROC_RUN_WATCHDOG_EN
  logic [WD_WIDTH-1:0] wd_limit_q;
`endif
  logic [WD_WIDTH-1:0] cycle_count_q;
  logic [WD_WIDTH-1:0] cycle_count_d;
  logic [63:0]         last_pc_q;
  logic                proc_resetl_q;
  logic                busy_q;
  logic                done_q;
  logic                timeout_q;

  assign cycle_count_d = cycle_count_q + WD_WIDTH'(1);

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q       <= ST_IDLE;
      rst_cnt_q     <= '0;
      start_pc_q    <= '0;
      final_pc_q    <= '0;
`ifdef PROC_RUN_WATCHDOG_EN
      wd_limit_q    <= '0;
`endif
      cycle_count_q <= '0;
      last_pc_q     <= '0;
      proc_resetl_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (bus.start) begin
            state_q       <= ST_RESET;
            rst_cnt_q     <= '0;
            start_pc_q    <= bus.start_pc;
            final_pc_q    <= bus.final_pc;
`ifdef PROC_RUN_WATCHDOG_EN
            wd_limit_q    <= bus.wd_limit;
`endif
            cycle_count_q <= '0;
            last_pc_q     <= '0;
            proc_resetl_q <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
          end
        end
        ST_RESET: begin
          if (rst_cnt_q == RC_LAST) begin
            state_q       <= ST_RUN;
            proc_resetl_q <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + RCW'(1);
          end
        end
        ST_RUN: begin
          cycle_count_q <= cycle_count_d;
          // Reaching the final PC wins over a watchdog expiry on the same cycle.
          if (bus.currentpc >= final_pc_q) begin
            state_q       <= ST_DONE;
            last_pc_q     <= bus.currentpc;
            proc_resetl_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end
`ifdef PROC_RUN_WATCHDOG_EN
          else if ((wd_limit_q != '0) && (cycle_count_d == wd_limit_q)) begin
            state_q       <= ST_TIMEOUT;
            last_pc_q     <= bus.currentpc;
            proc_resetl_q <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b1;
          end
`endif
        end
        default: begin
          state_q       <= ST_IDLE;
          proc_resetl_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.proc_resetl  = proc_resetl_q;
  assign bus.proc_startpc = start_pc_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;
  assign bus.cycle_count  = cycle_count_q;
  assign bus.last_pc      = last_pc_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: a PC+4 core model, run expectations queued at start and checked at run end.
module tb_proc_run_ctrl;

  localparam int RC  = 2;
  localparam int WDW = 16;
  localparam int EW  = 2 + WDW + 64;

  // clock / reset
  logic CLK    = 1'b0;
  logic resetl = 1'b0;
  always #5 CLK = ~CLK;

  proc_run_ctrl_if #(.WD_WIDTH(WDW)) bus ();

  proc_run_ctrl #(
    .RESET_CYCLES(RC),
    .WD_WIDTH    (WDW)
  ) dut (
    .CLK   (CLK),
    .resetl(resetl),
    .bus   (bus)
  );

  // core model: PC loads startpc while held in reset, then advances by 4 (or sticks)
  logic [63:0] pc_q;
  logic        stuck;
  always @(posedge CLK) begin
    if (!bus.proc_resetl) pc_q <= bus.proc_startpc;
    else if (!stuck)      pc_q <= pc_q + 64'd4;
  end
  assign bus.currentpc = pc_q;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_busy"},        64'(bus.busy),        64'd0);
    check({pfx, "_done"},        64'(bus.done),        64'd0);
    check({pfx, "_timeout"},     64'(bus.timeout),     64'd0);
    check({pfx, "_proc_resetl"}, 64'(bus.proc_resetl), 64'd0);
    check({pfx, "_startpc"},     bus.proc_startpc,     64'd0);
    check({pfx, "_cycle_count"}, 64'(bus.cycle_count), 64'd0);
    check({pfx, "_last_pc"},     bus.last_pc,          64'd0);
    check({pfx, "_state"},       64'(bus.dbg_state),   64'd0);
  endtask

  // drivers
  task automatic start_run(input logic [63:0] spc, input logic [63:0] fpc, input logic [WDW-1:0] wd);
    int rc;
    bus.start    = 1'b1;
    bus.start_pc = spc;
    bus.final_pc = fpc;
    bus.wd_limit = wd;
    @(negedge CLK);
    bus.start = 1'b0;
    check("go_busy",        64'(bus.busy),        64'd1);
    check("go_proc_resetl", 64'(bus.proc_resetl), 64'd0);
    check("go_done",        64'(bus.done),        64'd0);
    check("go_timeout",     64'(bus.timeout),     64'd0);
    check("go_startpc",     bus.proc_startpc,     spc);
    check("go_cycle_count", 64'(bus.cycle_count), 64'd0);
    rc = 0;
    while ((bus.proc_resetl == 1'b0) && (rc < 50)) begin
      rc++;
      @(negedge CLK);
    end
    check("reset_cycles", 64'(rc), 64'(RC));
  endtask

  task automatic finish_run(input logic [63:0] spc, input int pulse_at, input int budget);
    int runc;
    logic [EW-1:0] e;
    runc = 0;
    while (bus.busy && (runc < budget)) begin
      runc++;
      if (runc == pulse_at) begin
        bus.start    = 1'b1;
        bus.start_pc = 64'h100;
        bus.final_pc = '1;
        bus.wd_limit = WDW'(1);
      end
      @(negedge CLK);
      bus.start = 1'b0;
    end
    check("run_end_busy", 64'(bus.busy), 64'd0);
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("done",        64'(bus.done),        64'(e[EW-1]));
      check("timeout",     64'(bus.timeout),     64'(e[EW-2]));
      check("cycle_count", 64'(bus.cycle_count), 64'(e[64 +: WDW]));
      check("run_cycles",  64'(runc),            64'(e[64 +: WDW]));
      check("last_pc",     bus.last_pc,          e[63:0]);
    end
    check("stop_proc_resetl", 64'(bus.proc_resetl), 64'd0);
    check("hold_startpc",     bus.proc_startpc,     spc);
  endtask

  task automatic run_and_check(input logic [63:0] spc, input logic [63:0] fpc, input logic [WDW-1:0] wd,
                               input logic e_done, input logic e_to, input logic [WDW-1:0] e_cnt,
                               input logic [63:0] e_last, input int pulse_at);
    exp_q.push_back({e_done, e_to, e_cnt, e_last});
    start_run(spc, fpc, wd);
    finish_run(spc, pulse_at, 1000);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finished");
    $fatal(1);
  end

  initial begin
    logic [63:0] spc;
    int k;
    stuck        = 1'b0;
    bus.start    = 1'b0;
    bus.start_pc = '0;
    bus.final_pc = '0;
    bus.wd_limit = '0;
    resetl       = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_values("por");
    resetl = 1'b1;
    @(negedge CLK);
    check("idle_state", 64'(bus.dbg_state), 64'd0);

    // run to completion, then back-to-back start from DONE
    run_and_check(64'h0,  64'h14, 16'hFF, 1'b1, 1'b0, 16'd6, 64'h14, -1);
    run_and_check(64'h40, 64'h50, 16'hFF, 1'b1, 1'b0, 16'd5, 64'h50, -1);
    // immediate completion
    run_and_check(64'h20, 64'h14, 16'hFF, 1'b1, 1'b0, 16'd1, 64'h20, -1);
    // done beats watchdog on the same cycle; start pulsed mid-run is ignored
    run_and_check(64'h0,  64'h14, 16'd6,  1'b1, 1'b0, 16'd6, 64'h14, 2);

    // watchdog expiry with the PC stuck
    stuck = 1'b1;
`ifdef PROC_RUN_WATCHDOG_EN
    run_and_check(64'h8, 64'h14, 16'hFF, 1'b0, 1'b1, 16'hFF, 64'h8, -1);
`else
    start_run(64'h8, 64'h14, 16'hFF);
    repeat (300) @(negedge CLK);
    check("nowd_busy",    64'(bus.busy),    64'd1);
    check("nowd_timeout", 64'(bus.timeout), 64'd0);
    check("nowd_done",    64'(bus.done),    64'd0);
    resetl = 1'b0;
    @(negedge CLK);
    resetl = 1'b1;
    check_reset_values("nowd_rst");
`endif
    stuck = 1'b0;

    // reset asserted on RUN cycle 3
    start_run(64'h0, 64'h14, 16'hFF);
    repeat (2) @(negedge CLK);
    check("mid_run_busy", 64'(bus.busy), 64'd1);
    resetl = 1'b0;
    @(negedge CLK);
    check_reset_values("midrst");
    resetl = 1'b1;
    @(negedge CLK);
    run_and_check(64'h0, 64'h14, 16'hFF, 1'b1, 1'b0, 16'd6, 64'h14, -1);

    // random runs ending on the final PC
    for (int r = 0; r < 4; r++) begin
      spc = 64'($urandom_range(0, 4000)) << 2;
      k   = $urandom_range(1, 20);
      run_and_check(spc, spc + 64'(4 * (k - 1)), (r % 2 == 0) ? WDW'(0) : WDW'(k + 3),
                    1'b1, 1'b0, WDW'(k), spc + 64'(4 * (k - 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
